// File: rtl/qr_act_pkg.sv
// Shared types and helpers for the quantized-activation unpacker.
// Holds the FSM state encoding, legal element widths and lane-count arithmetic.
package qr_act_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EMIT
    } act_unpack_state_t;

    localparam logic [3:0] BITS_INT2 = 4'd2;
    localparam logic [3:0] BITS_INT4 = 4'd4;
    localparam logic [3:0] BITS_INT8 = 4'd8;

    // Anything other than 2 or 4 is handled as an INT8 element.
    function automatic logic [3:0] norm_bits(input logic [3:0] bits);
        case (bits)
            BITS_INT2: return BITS_INT2;
            BITS_INT4: return BITS_INT4;
            default:   return BITS_INT8;
        endcase
    endfunction

    function automatic int lanes_per_word(input logic [3:0] bits, input int word_width);
        case (bits)
            BITS_INT2: return word_width >> 1;
            BITS_INT4: return word_width >> 2;
            default:   return word_width >> 3;
        endcase
    endfunction

endpackage

// File: rtl/act_lane_extract.sv
// Combinational lane picker: selects one packed element from a word, extends it
// according to signedness and subtracts the extended zero point.
module act_lane_extract
    import qr_act_pkg::*;
#(
    parameter int wordWidth     = 32,
    parameter int maxInputWidth = 8,
    parameter int outWidth      = 10,
    parameter int laneWidth     = 4
) (
    input  logic [wordWidth-1:0]     word,
    input  logic [laneWidth-1:0]     lane,
    input  logic [3:0]               bits,
    input  logic                     is_unsigned,
    input  logic [maxInputWidth-1:0] zero_point,
    output logic [outWidth-1:0]      out_data
);

    localparam int SHW = $clog2(wordWidth);

    logic [SHW-1:0]           shamt;
    logic [maxInputWidth-1:0] field;
    logic                     sign_en;
    logic [outWidth-1:0]      raw_ext;
    logic [outWidth-1:0]      zp_ext;

    // Bit offset is lane*bits; widths are powers of two so a shift suffices.
    always_comb begin
        sign_en = !is_unsigned;
        case (bits)
            BITS_INT2: shamt = SHW'({lane, 1'b0});
            BITS_INT4: shamt = SHW'({lane, 2'b00});
            default:   shamt = SHW'({lane, 3'b000});
        endcase
        field = maxInputWidth'(word >> shamt);
        case (bits)
            BITS_INT2: raw_ext = {{(outWidth-2){sign_en & field[1]}}, field[1:0]};
            BITS_INT4: raw_ext = {{(outWidth-4){sign_en & field[3]}}, field[3:0]};
            default:   raw_ext = {{(outWidth-8){sign_en & field[7]}}, field[7:0]};
        endcase
        zp_ext   = {{(outWidth-maxInputWidth){sign_en & zero_point[maxInputWidth-1]}}, zero_point};
        out_data = raw_ext - zp_ext;
    end

endmodule

// File: rtl/act_unpacker.sv
// Streams zero-point-corrected INT2/4/8 activations, one per beat, from packed words.
// Optional ACT_UNPACKER_STALL_CNT_EN adds a saturating stall_cnt output.
module act_unpacker
    import qr_act_pkg::*;
#(
    parameter int wordWidth     = 32,
    parameter int maxInputWidth = 8,
    parameter int outWidth      = 10,
    parameter int cntWidth      = 16
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     start,
    input  logic                     cfg_unsigned,
    input  logic [3:0]               cfg_input_bits,
    input  logic [maxInputWidth-1:0] cfg_zero_point,
    input  logic [cntWidth-1:0]      cfg_num_elems,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [wordWidth-1:0]     in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [outWidth-1:0]      out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
`ifdef ACT_UNPACKER_STALL_CNT_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);

    localparam int LANE_W = $clog2(wordWidth / 2);

    act_unpack_state_t        state, state_nxt;
    logic [wordWidth-1:0]     word_q;
    logic [LANE_W-1:0]        lane_q;
    logic [cntWidth-1:0]      elem_cnt;
    logic [cntWidth-1:0]      num_q;
    logic [3:0]               bits_q;
    logic                     uns_q;
    logic [maxInputWidth-1:0] zp_q;
    logic                     done_q;
    logic                     done_nxt;
    logic                     start_ok;
    logic                     in_hs;
    logic                     out_hs;
    logic                     final_elem;
    logic                     last_lane;

    assign final_elem = (elem_cnt == (num_q - cntWidth'(1)));
    assign last_lane  = (lane_q == LANE_W'(lanes_per_word(bits_q, wordWidth) - 1));

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        start_ok  = 1'b0;
        in_hs     = (state == LOAD) && in_valid;
        out_hs    = (state == EMIT) && out_ready;
        case (state)
            IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    if (cfg_num_elems == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                if (in_valid) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (final_elem) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else if (last_lane) begin
                        state_nxt = LOAD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == EMIT);
    assign busy      = (state != IDLE);
    assign out_last  = out_valid && final_elem;
    assign done      = done_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
        end
    end

    // Configuration is frozen for the whole tensor once start is accepted.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bits_q <= BITS_INT8;
            uns_q  <= 1'b0;
            zp_q   <= '0;
            num_q  <= '0;
        end else if (start_ok) begin
            bits_q <= norm_bits(cfg_input_bits);
            uns_q  <= cfg_unsigned;
            zp_q   <= cfg_zero_point;
            num_q  <= cfg_num_elems;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            word_q   <= '0;
            lane_q   <= '0;
            elem_cnt <= '0;
        end else begin
            if (in_hs) begin
                word_q <= in_data;
                lane_q <= '0;
            end else if (out_hs && !last_lane) begin
                lane_q <= lane_q + LANE_W'(1);
            end
            if (start_ok) begin
                elem_cnt <= '0;
            end else if (out_hs) begin
                elem_cnt <= elem_cnt + cntWidth'(1);
            end
        end
    end

    act_lane_extract #(
        .wordWidth    (wordWidth),
        .maxInputWidth(maxInputWidth),
        .outWidth     (outWidth),
        .laneWidth    (LANE_W)
    ) u_extract (
        .word       (word_q),
        .lane       (lane_q),
        .bits       (bits_q),
        .is_unsigned(uns_q),
        .zero_point (zp_q),
        .out_data   (out_data)
    );

`ifdef ACT_UNPACKER_STALL_CNT_EN
    logic stall_event;
    assign stall_event = ((state == EMIT) && !out_ready) || ((state == LOAD) && !in_valid);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cnt <= '0;
        end else if (start_ok) begin
            stall_cnt <= '0;
        end else if (stall_event && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_act_unpacker.sv
// Self-checking bench for act_unpacker: directed tensors, random backpressured tensors
// and a mid-tensor reset, all checked against an arithmetic reference model.
module tb_act_unpacker;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic        cfg_unsigned;
    logic [3:0]  cfg_input_bits;
    logic [7:0]  cfg_zero_point;
    logic [15:0] cfg_num_elems;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef ACT_UNPACKER_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] tensor_words[$];
    int          exp_q[$];

    act_unpacker dut (
        .clk           (clk),
        .nrst          (nrst),
        .start         (start),
        .cfg_unsigned  (cfg_unsigned),
        .cfg_input_bits(cfg_input_bits),
        .cfg_zero_point(cfg_zero_point),
        .cfg_num_elems (cfg_num_elems),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done)
`ifdef ACT_UNPACKER_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int elem_bits(input logic [3:0] bits_cfg);
        if (bits_cfg == 4'd2) return 2;
        if (bits_cfg == 4'd4) return 4;
        return 8;
    endfunction

    // Reference: element i lives in word i/lanes at lane i%lanes; value minus zero point.
    function automatic void build_expected(input bit uns, input logic [3:0] bits_cfg,
                                           input logic [7:0] zp, input int n);
        int b, lpw, zpv, raw;
        logic [31:0] w;
        b   = elem_bits(bits_cfg);
        lpw = 32 / b;
        zpv = uns ? int'(zp) : int'($signed(zp));
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            w   = tensor_words[i / lpw];
            raw = int'((w >> ((i % lpw) * b)) & ((32'd1 << b) - 32'd1));
            if (!uns && raw >= (1 << (b - 1))) raw -= (1 << b);
            exp_q.push_back(raw - zpv);
        end
    endfunction

    task automatic scramble_cfg();
        cfg_unsigned   = 1'($urandom);
        cfg_input_bits = 4'($urandom);
        cfg_zero_point = 8'($urandom);
        cfg_num_elems  = 16'($urandom_range(0, 50));
    endtask

    task automatic applyStimulus(input bit uns, input logic [3:0] bits_cfg, input logic [7:0] zp,
                                 input int n, input bit bp, input int abort_after);
        int lpw, nwords, word_idx, popped, cycles, held, e;
        bit stalled, expect_done;
        build_expected(uns, bits_cfg, zp, n);
        lpw         = 32 / elem_bits(bits_cfg);
        nwords      = (n + lpw - 1) / lpw;
        word_idx    = 0;
        popped      = 0;
        cycles      = 0;
        held        = 0;
        stalled     = 1'b0;
        expect_done = 1'b0;

        @(negedge clk);
        cfg_unsigned   = uns;
        cfg_input_bits = bits_cfg;
        cfg_zero_point = zp;
        cfg_num_elems  = 16'(n);
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble_cfg();

        if (n == 0) begin
            checkOutput("zero_done", done, 1);
            checkOutput("zero_busy", busy, 0);
            @(negedge clk);
            checkOutput("zero_done_clear", done, 0);
            return;
        end

        while (1) begin
            if (cycles > 3000) begin
                checkOutput("timeout", 0, 1);
                break;
            end
            cycles++;
            if (expect_done) begin
                start = 1'b0;
                checkOutput("done_pulse", done, 1);
                checkOutput("busy_after", busy, 0);
                checkOutput("valid_after", out_valid, 0);
                @(negedge clk);
                checkOutput("done_clear", done, 0);
                break;
            end
            checkOutput("done_early", done, 0);
            if (stalled) begin
                checkOutput("stall_hold", int'($signed(out_data)), held);
                checkOutput("stall_valid", out_valid, 1);
            end
            checkOutput("ready_in_emit", in_ready & out_valid, 0);
            stalled   = 1'b0;
            out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("extra_elem", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("out_data", int'($signed(out_data)), e);
                        checkOutput("out_last", out_last, (exp_q.size() == 0) ? 1 : 0);
                        popped++;
                        if (exp_q.size() == 0) expect_done = 1'b1;
                    end
                end else begin
                    stalled = 1'b1;
                    held    = int'($signed(out_data));
                end
            end
            in_valid = (word_idx < nwords) && (bp ? ($urandom_range(0, 3) != 0) : 1'b1);
            in_data  = in_valid ? tensor_words[word_idx] : $urandom;
            if (in_valid && in_ready) word_idx++;
            start = ($urandom_range(0, 7) == 0);
            scramble_cfg();
            if (abort_after >= 0 && popped == abort_after) return;
            @(negedge clk);
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int n, nw;
        logic [3:0] b;
        nrst      = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        scramble_cfg();
        #2;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_out_last", out_last, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        tensor_words = '{32'h807F01FF};
        applyStimulus(1'b0, 4'd8, 8'd0, 4, 1'b0, -1);
        tensor_words = '{32'h00FF8081};
        applyStimulus(1'b1, 4'd8, 8'd128, 4, 1'b0, -1);
        tensor_words = '{32'h76543210, 32'h000000F8};
        applyStimulus(1'b0, 4'd4, 8'hFD, 10, 1'b0, -1);
        tensor_words = '{32'hFFFFFFFF};
        applyStimulus(1'b1, 4'd2, 8'd255, 16, 1'b0, -1);
        applyStimulus(1'b0, 4'd8, 8'd0, 0, 1'b0, -1);

        for (int t = 0; t < 25; t++) begin
            b  = 4'($urandom);
            n  = $urandom_range(1, 40);
            nw = (n + (32 / elem_bits(b)) - 1) / (32 / elem_bits(b));
            tensor_words.delete();
            for (int k = 0; k < nw; k++) tensor_words.push_back($urandom);
            applyStimulus(1'($urandom), b, 8'($urandom), n, 1'b1, -1);
        end

        tensor_words = '{32'h11223344, 32'h55667788};
        applyStimulus(1'b0, 4'd8, 8'd5, 8, 1'b0, 2);
        @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_in_ready", in_ready, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_out_last", out_last, 0);
        checkOutput("abort_out_data", int'(out_data), 0);
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("abort_no_done", done, 0);
        end

        tensor_words = '{32'hA5C3_0F81};
        applyStimulus(1'b1, 4'd4, 8'd7, 8, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
